// File: rtl/mux8_arbiter.sv
// Round-robin arbiter granting one mux8 datapath to one of eight requesters.
// Optional hold timeout enabled by defining MUX8_ARB_TIMEOUT_EN (limit set by HOLD_MAX).
module mux8_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
        $error("mux8_arbiter: HOLD_MAX must be within 1..255");
    end

    logic [0:0] state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;

    logic [2:0] win;
    logic [2:0] idx;
    logic       hit;
    logic       tmo;

    // First requester at or after ptr, wrapping modulo 8 via 3-bit arithmetic.
    always_comb begin
        win = '0;
        idx = '0;
        hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
    end

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    assign tmo = (cnt_q == HOLD_LAST);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = GRANT;
                    gnt_d   = 8'b1 << win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                // sel_q holds the owner index for the whole grant.
                if (!req[sel_q] || tmo) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 3'd1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt          = gnt_q;
    assign {s2, s1, s0} = sel_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Bench for mux8_arbiter: per-cycle comparison against an abstract round-robin model
// plus directed literal checks; HOLD_MAX = 4 so the timeout build is exercised.
module tb_mux8_arbiter;

    localparam int HOLD = 4;
`ifdef MUX8_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       s0, s1, s2, busy;

    int n_cmp = 0;
    int n_bad = 0;

    mux8_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt),
        .s0  (s0),
        .s1  (s1),
        .s2  (s2),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Abstract model: owner index (-1 = none), priority pointer, select, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_hold  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sel   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 8; k++)
                if (m_owner < 0 && req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
            if (m_owner >= 0) begin
                m_sel  = m_owner;
                m_hold = 1;
            end
        end else if (!req[m_owner] || (TMO && m_hold >= HOLD)) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else begin
            m_hold++;
        end
    end

    function automatic logic [7:0] m_gnt();
        return (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_gnt", 32'(gnt), 32'(m_gnt()));
        chk("cyc_sel", 32'({s2, s1, s0}), 32'(m_sel));
        chk("cyc_busy", 32'(busy), 32'(m_owner >= 0));
    end

    // Literal expectation: pins both the DUT and the model.
    task automatic lit(input string nm, input logic [7:0] eg, input logic [2:0] es);
        chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
        chk({nm, "_sel"}, 32'({s2, s1, s0}), 32'(es));
        chk({nm, "_busy"}, 32'(busy), 32'(eg != 8'h00));
        chk({nm, "_model"}, 32'(m_gnt()), 32'(eg));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    logic [7:0] tseq [11];
    int ign_n;

    initial begin
        rst = 1'b1;
        req = 8'h00;
        tick(2);
        lit("reset", 8'h00, 3'd0);

        // Reset asserted mid-grant with all requesting.
        rst = 1'b0;
        req = 8'hFF;
        tick(1);
        lit("first_grant", 8'h01, 3'd0);
        tick(1);
        #1 rst = 1'b1;
        #1 lit("async_rst", 8'h00, 3'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        lit("post_rst", 8'h01, 3'd0);

        // Rotation 0..7: each owner holds 2 cycles, drops, re-asserts.
        for (int i = 0; i < 8; i++) begin
            lit("rot", 8'(1 << i), 3'(i));
            tick(1);
            req[i] = 1'b0;
            tick(1);
            lit("rot_idle", 8'h00, 3'(i));
            req[i] = 1'b1;
            tick(1);
        end
        lit("rot_wrap", 8'h01, 3'd0);

        // Sparse with wrap: after 6, requests {5,0} must serve 0 first.
        req = 8'h40;
        tick(1);
        lit("sp_rel0", 8'h00, 3'd0);
        tick(1);
        lit("sp_g6", 8'h40, 3'd6);
        req = 8'b0010_0001;
        tick(1);
        lit("sp_rel6", 8'h00, 3'd6);
        tick(1);
        lit("sp_g0", 8'h01, 3'd0);
        req = 8'h20;
        tick(1);
        lit("sp_rel0b", 8'h00, 3'd0);
        tick(1);
        lit("sp_g5", 8'h20, 3'd5);

        // Others toggle while 3 owns the mux.
        req = 8'h00;
        tick(1);
        req = 8'h08;
        tick(1);
        lit("ign_g3", 8'h08, 3'd3);
        ign_n = TMO ? HOLD - 1 : 10;
        for (int k = 0; k < ign_n; k++) begin
            req = 8'h08 | ((k % 2 == 0) ? 8'h14 : 8'h00);
            tick(1);
            lit("ign_hold", 8'h08, 3'd3);
        end
        req = 8'h00;
        tick(1);
        lit("ign_rel", 8'h00, 3'd3);

        // Two requesters that never release.
        if (TMO) tseq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02,
                          8'h02, 8'h02, 8'h02, 8'h00, 8'h01};
        else     tseq = '{default: 8'h01};
        req = 8'h03;
        tick(1);
        for (int j = 0; j < 11; j++) begin
            lit("tmo", tseq[j], (tseq[j] == 8'h02) ? 3'd1 : 3'd0);
            tick(1);
        end
        req = 8'h00;
        tick(1);
        lit("tmo_rel", 8'h00, 3'd0);

        // Single requester re-wins; ptr lands on 6 after its release.
        req = 8'h20;
        tick(1);
        lit("rewin_a", 8'h20, 3'd5);
        tick(2);
        req = 8'h00;
        tick(1);
        lit("rewin_rel", 8'h00, 3'd5);
        req = 8'h20;
        tick(1);
        lit("rewin_b", 8'h20, 3'd5);
        tick(2);
        req = 8'h00;
        tick(1);
        req = 8'h61;
        tick(1);
        lit("ptr6", 8'h40, 3'd6);
        req = 8'h00;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
